// File: rtl/alu_rxd_seq_pkg.sv
// Shared definitions for the RLD/RRD read-modify-write sequencer:
// state encodings, Z80 flag bit positions and the ack timeout counter width.
package alu_rxd_seq_pkg;

  typedef enum logic [2:0] {
    RXD_IDLE = 3'd0,
    RXD_RD   = 3'd1,
    RXD_CALC = 3'd2,
    RXD_WR   = 3'd3,
    RXD_DONE = 3'd4
  } rxd_state_t;

  // Flag byte layout {S,Z,b5,H,b3,P/V,N,C}
  localparam int FLG_S  = 7;
  localparam int FLG_Z  = 6;
  localparam int FLG_B5 = 5;
  localparam int FLG_H  = 4;
  localparam int FLG_B3 = 3;
  localparam int FLG_PV = 2;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 0;

  localparam int TMO_W = 8;

  function automatic logic even_parity(input logic [7:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/alu_rxd_seq_calc.sv
// Combinational nibble rotate between A and a memory byte for RLD/RRD,
// plus the resulting flag byte. Kept standalone so a formal model can reuse it.
module rxd_calc
  import alu_rxd_seq_pkg::*;
(
  input  logic       rrd_sel,
  input  logic [7:0] a,
  input  logic [7:0] m,
  input  logic       c,
  output logic [7:0] mem_new,
  output logic [7:0] a_new,
  output logic [7:0] flags
);

  always_comb begin
    if (rrd_sel) begin
      mem_new = {a[3:0], m[7:4]};
      a_new   = {a[7:4], m[3:0]};
    end else begin
      mem_new = {m[3:0], a[3:0]};
      a_new   = {a[7:4], m[7:4]};
    end

    // H and N are always cleared by RLD/RRD; C passes through untouched
    flags         = '0;
    flags[FLG_S]  = a_new[7];
    flags[FLG_Z]  = (a_new == 8'h00);
    flags[FLG_B5] = a_new[5];
    flags[FLG_H]  = 1'b0;
    flags[FLG_B3] = a_new[3];
    flags[FLG_PV] = even_parity(a_new);
    flags[FLG_N]  = 1'b0;
    flags[FLG_C]  = c;
  end

endmodule

// File: rtl/alu_rxd_seq.sv
// Read-modify-write sequencer for the memory operand of RLD/RRD: reads (HL),
// rotates nibbles with A, writes the byte back and returns new A plus flags.
module alu_rxd_seq
  import alu_rxd_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ACK_TMO = 255
) (
  input  logic              clkc,
  input  logic              reset,
  input  logic              start,
  input  logic              rrd_sel,
  input  logic [7:0]        a_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              carry_bit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        a_out,
  output logic [7:0]        flag_out
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  rxd_state_t state_q, state_d;

  logic              rrd_q;
  logic [7:0]        a_q;
  logic [ADDR_W-1:0] hl_q;
  logic              c_q;
  logic [7:0]        m_q;
  logic [7:0]        mem_new_q;
  logic [7:0]        a_new_q;
  logic [7:0]        flags_q;
  logic [TMO_W-1:0]  cnt_q;
  logic [7:0]        a_out_q;
  logic [7:0]        flag_out_q;
  logic              err_q;

  logic [7:0] calc_mem_new;
  logic [7:0] calc_a_new;
  logic [7:0] calc_flags;

  logic rd_req_c;
  logic wr_req_c;
  logic load_in;
  logic latch_m;
  logic calc_en;
  logic cnt_clr;
  logic cnt_inc;
  logic finish_ok;
  logic finish_err;

  rxd_calc u_calc (
    .rrd_sel (rrd_q),
    .a       (a_q),
    .m       (m_q),
    .c       (c_q),
    .mem_new (calc_mem_new),
    .a_new   (calc_a_new),
    .flags   (calc_flags)
  );

  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      state_q <= RXD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_req_c   = 1'b0;
    wr_req_c   = 1'b0;
    load_in    = 1'b0;
    latch_m    = 1'b0;
    calc_en    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;

    unique case (state_q)
      RXD_IDLE: begin
        if (start) begin
          load_in = 1'b1;
          cnt_clr = 1'b1;
          state_d = RXD_RD;
        end
      end
      RXD_RD: begin
        rd_req_c = 1'b1;
        if (mem_ack) begin
          latch_m = 1'b1;
          state_d = RXD_CALC;
        end else if (cnt_q == TMO_LAST) begin
          // abandon the read: nothing is written back on this path
          finish_err = 1'b1;
          state_d    = RXD_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RXD_CALC: begin
        calc_en = 1'b1;
        cnt_clr = 1'b1;
        state_d = RXD_WR;
      end
      RXD_WR: begin
        wr_req_c = 1'b1;
        if (mem_ack) begin
          finish_ok = 1'b1;
          state_d   = RXD_DONE;
        end else if (cnt_q == TMO_LAST) begin
          finish_err = 1'b1;
          state_d    = RXD_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RXD_DONE: begin
        state_d = RXD_IDLE;
      end
      default: begin
        state_d = RXD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      rrd_q <= 1'b0;
      a_q   <= '0;
      hl_q  <= '0;
      c_q   <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (load_in) begin
        rrd_q <= rrd_sel;
        a_q   <= a_in;
        hl_q  <= addr_in;
        c_q   <= carry_bit;
      end
      if (latch_m) begin
        m_q <= mem_rdata;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      mem_new_q <= '0;
      a_new_q   <= '0;
      flags_q   <= '0;
    end else if (calc_en) begin
      mem_new_q <= calc_mem_new;
      a_new_q   <= calc_a_new;
      flags_q   <= calc_flags;
    end
  end

  // Results land on entry to DONE so they are valid alongside the done pulse
  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      a_out_q    <= '0;
      flag_out_q <= '0;
      err_q      <= 1'b0;
    end else if (finish_ok) begin
      a_out_q    <= a_new_q;
      flag_out_q <= flags_q;
      err_q      <= 1'b0;
    end else if (finish_err) begin
      a_out_q <= a_q;
      err_q   <= 1'b1;
    end
  end

  assign mem_rd_req = rd_req_c;
  assign mem_wr_req = wr_req_c;
  assign mem_addr   = (rd_req_c || wr_req_c) ? hl_q : '0;
  assign mem_wdata  = wr_req_c ? mem_new_q : '0;
  assign busy       = (state_q != RXD_IDLE);
  assign done       = (state_q == RXD_DONE);
  assign err        = err_q;
  assign a_out      = a_out_q;
  assign flag_out   = flag_out_q;

endmodule

// File: tb/tb_alu_rxd_seq.sv
// Randomized self-checking bench for alu_rxd_seq with a nibble-arithmetic
// reference model and a bench-side memory responder with programmable waits.
module tb_alu_rxd_seq;

  localparam int ADDR_W = 16;
  localparam int TMO    = 4;
  localparam int NEVER  = 99;

  logic              clkc = 1'b0;
  logic              reset;
  logic              start;
  logic              rrd_sel;
  logic [7:0]        a_in;
  logic [ADDR_W-1:0] addr_in;
  logic              carry_bit;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        a_out;
  logic [7:0]        flag_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] flag_model = 8'h00;
  logic [7:0] aout_model = 8'h00;

  alu_rxd_seq #(.ADDR_W(ADDR_W), .ACK_TMO(TMO)) dut (
    .clkc       (clkc),
    .reset      (reset),
    .start      (start),
    .rrd_sel    (rrd_sel),
    .a_in       (a_in),
    .addr_in    (addr_in),
    .carry_bit  (carry_bit),
    .mem_addr   (mem_addr),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .a_out      (a_out),
    .flag_out   (flag_out)
  );

  always #5 clkc = ~clkc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] ref_flags(input int a, input logic c);
    logic [7:0] f;
    f    = 8'h00;
    f[7] = (a >= 128);
    f[6] = (a == 0);
    f[5] = ((a / 32) % 2) == 1;
    f[3] = ((a / 8) % 2) == 1;
    f[2] = ($countones(a[7:0]) % 2) == 0;
    f[0] = c;
    return f;
  endfunction

  task automatic run_op(input logic rrd, input logic [7:0] a, input logic [15:0] hl,
                        input logic c, input logic [7:0] m,
                        input int rd_wait, input int wr_wait, input bit poke_start);
    int lo_a, hi_a, lo_m, hi_m, wexp, anew, lat, exp_rd_n, exp_wr_n;
    int cyc, rd_n, wr_n, done_cyc;
    bit rd_to, wr_to, got_done, err_exp;
    logic [7:0] aout_exp, flag_exp;

    lo_a = a % 16; hi_a = a / 16; lo_m = m % 16; hi_m = m / 16;
    if (!rrd) begin
      wexp = lo_m * 16 + lo_a;
      anew = hi_a * 16 + hi_m;
    end else begin
      wexp = lo_a * 16 + hi_m;
      anew = hi_a * 16 + lo_m;
    end
    rd_to = (rd_wait >= TMO);
    wr_to = !rd_to && (wr_wait >= TMO);
    err_exp = rd_to || wr_to;
    if (rd_to)      lat = TMO + 1;
    else if (wr_to) lat = rd_wait + TMO + 3;
    else            lat = rd_wait + wr_wait + 4;
    exp_rd_n = rd_to ? TMO : rd_wait + 1;
    exp_wr_n = rd_to ? 0 : (wr_to ? TMO : wr_wait + 1);
    aout_exp = err_exp ? a : 8'(anew);
    flag_exp = err_exp ? flag_model : ref_flags(anew, c);

    @(negedge clkc);
    start = 1'b1; rrd_sel = rrd; a_in = a; addr_in = hl; carry_bit = c; mem_ack = 1'b0;
    @(negedge clkc);
    start = 1'b0;
    rrd_sel = 1'($urandom); a_in = 8'($urandom); addr_in = 16'($urandom); carry_bit = 1'($urandom);
    cyc = 1; rd_n = 0; wr_n = 0; got_done = 0; done_cyc = 0;
    chk("a_out_hold", a_out, aout_model);
    while (!got_done && cyc < 64) begin
      chk("req_excl", {31'd0, mem_rd_req & mem_wr_req}, 0);
      mem_ack = 1'b0;
      start = 1'b0;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end else if (mem_rd_req) begin
        chk("rd_addr", 32'(mem_addr), 32'(hl));
        rd_n++;
        if (rd_n == rd_wait + 1) begin
          mem_ack = 1'b1;
          mem_rdata = m;
        end else begin
          mem_rdata = 8'($urandom);
        end
      end else if (mem_wr_req) begin
        chk("wr_addr", 32'(mem_addr), 32'(hl));
        chk("wdata", 32'(mem_wdata), 32'(wexp));
        wr_n++;
        if (poke_start && wr_n == 1) start = 1'b1;
        if (wr_n == wr_wait + 1) mem_ack = 1'b1;
      end else begin
        mem_ack = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      if (!got_done) begin
        @(negedge clkc);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    chk("done_seen", {31'd0, got_done}, 1);
    chk("latency", done_cyc, lat);
    chk("rd_cycles", rd_n, exp_rd_n);
    chk("wr_cycles", wr_n, exp_wr_n);
    chk("err", {31'd0, err}, {31'd0, err_exp});
    chk("a_out", a_out, aout_exp);
    chk("flag_out", flag_out, flag_exp);
    chk("busy_in_done", {31'd0, busy}, 1);
    flag_model = flag_exp;
    aout_model = aout_exp;
    @(negedge clkc);
    chk("done_pulse", {31'd0, done}, 0);
    chk("busy_idle", {31'd0, busy}, 0);
    if (poke_start) begin
      repeat (3) begin
        @(negedge clkc);
        chk("no_requeue", {29'd0, busy, done, mem_rd_req}, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rrd_sel = 1'b0; a_in = '0; addr_in = '0;
    carry_bit = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clkc);
    chk("rst_outs", {mem_rd_req, mem_wr_req, busy, done, err, 3'd0, a_out, flag_out}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    reset = 1'b0;

    run_op(1'b0, 8'h7A, 16'h1234, 1'b0, 8'h31, 0, 0, 0);
    run_op(1'b1, 8'h84, 16'h4000, 1'b1, 8'h20, 3, 3, 0);
    run_op(1'b0, 8'h05, 16'h0010, 1'b0, 8'h00, 1, 0, 0);
    run_op(1'b1, 8'h5C, 16'hBEEF, 1'b1, 8'h9D, NEVER, 0, 0);
    run_op(1'b0, 8'hE3, 16'h0FF0, 1'b0, 8'h6B, 1, NEVER, 0);
    run_op(1'b1, 8'h3C, 16'h8001, 1'b0, 8'hA5, TMO - 1, TMO - 1, 0);
    run_op(1'b0, 8'h91, 16'h2222, 1'b1, 8'h4E, 0, 2, 1);

    @(negedge clkc);
    start = 1'b1; rrd_sel = 1'b0; a_in = 8'h12; addr_in = 16'hCAFE; carry_bit = 1'b1;
    @(negedge clkc);
    start = 1'b0;
    chk("rd_before_rst", {31'd0, mem_rd_req}, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {mem_rd_req, mem_wr_req, busy, done, err, 3'd0, a_out, flag_out}, 0);
    chk("rst_mid_bus", {mem_addr, mem_wdata}, 0);
    @(negedge clkc);
    reset = 1'b0;
    flag_model = 8'h00;
    aout_model = 8'h00;
    run_op(1'b1, 8'h12, 16'hCAFE, 1'b1, 8'h77, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int rw, ww;
      rw = ($urandom_range(0, 9) == 9) ? NEVER : int'($urandom_range(0, 3));
      ww = ($urandom_range(0, 9) == 9) ? NEVER : int'($urandom_range(0, 3));
      run_op(1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), 8'($urandom),
             rw, ww, ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_rxd_seq.md
Name: alu_rxd_seq

Overview:
- Multi-cycle read-modify-write sequencer for the RLD/RRD nibble-rotate instructions.
- Handles the memory-operand side of rotates; the register-side 8-bit shifter stays combinational.
- Launched by the control unit with A and HL:
  - reads (HL) over a req/ack byte interface;
  - rotates nibbles between A and the memory byte;
  - writes the memory byte back;
  - returns new A plus a Z80-format flag byte.

Parameters:
- ADDR_W, 16, memory address width.
- ACK_TMO, 255, max cycles to wait for mem_ack per access before abort (≥1, counter is 8 bits).

Ports:
- clkc  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch strobe, sampled only in IDLE.
- rrd_sel  in  1  1=RRD, 0=RLD, captured at start.
- a_in  in  8  accumulator value, captured at start.
- addr_in  in  ADDR_W  HL value, captured at start.
- carry_bit  in  1  current C flag, captured at start.
- mem_addr  out  ADDR_W  access address.
- mem_rd_req  out  1  read request, level, held until ack.
- mem_wr_req  out  1  write request, level, held until ack.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid in the cycle mem_ack=1 during a read.
- mem_ack  in  1  access-complete strobe.
- busy  out  1  high from cycle after start through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = ack timeout abort.
- a_out  out  8  new accumulator, valid with done, held until next done.
- flag_out  out  8  {S,Z,b5,H,b3,P/V,N,C}, valid with done, held until next done.

Behaviour:
- Reset values (async, immediate): state IDLE; all outputs 0 (mem_addr, mem_wdata, a_out, flag_out, err included); timeout counter 0.
- States and transitions:
  - IDLE: start=1 captures inputs → RD. start while not IDLE is ignored, not queued.
  - RD: mem_rd_req=1, mem_addr=captured HL.
    - mem_ack=1: latch mem_rdata → CALC.
  - CALC: one cycle; compute results.
    - RLD: mem_new={m[3:0],a[3:0]}, a_new={a[7:4],m[7:4]}.
    - RRD: mem_new={a[3:0],m[7:4]}, a_new={a[7:4],m[3:0]}.
    - → WR.
  - WR: mem_wr_req=1, mem_wdata=mem_new, mem_addr=HL.
    - mem_ack=1 → DONE.
  - DONE: done=1 for one cycle, a_out/flag_out/err updated → IDLE.
- Latency: start → done = 4 cycles with zero-wait ack (ack in the first cycle of RD and of WR); each wait cycle adds 1.
- Request/ack rules:
  - rd_req and wr_req are never both high.
  - A request drops in the cycle after ack.
  - mem_ack outside RD/WR is ignored.
- Flags, from a_new:
  - S=a_new[7]; Z=(a_new==0); b5=a_new[5]; b3=a_new[3].
  - H=0; N=0; C=captured carry_bit.
  - P/V=1 when a_new has even parity.
- Timeout:
  - Counter clears on entry to RD and to WR, and increments each non-ack cycle.
  - Reaching ACK_TMO drops the request → DONE with err=1.
  - On abort, a_out=captured a_in and flag_out is unchanged.
  - A read timeout performs no write.
- Reset mid-operation: any state → IDLE at once; requests deassert asynchronously; no done pulse.
- busy is low in IDLE and high in RD/CALC/WR/DONE.

Decomposition:
- Shared package/include:
  - state encodings (RXD_IDLE, RXD_RD, RXD_CALC, RXD_WR, RXD_DONE);
  - flag bit indices (FLG_S=7, FLG_Z=6, FLG_H=4, FLG_PV=2, FLG_N=1, FLG_C=0).
- One combinational sub-module, rxd_calc: rrd_sel, a, m, c in → mem_new, a_new, flags out. It is reusable by a formal model.

Test Plan:
- RLD, A=0x7A, (0x1234)=0x31, C=0, zero-wait ack → write 0x1A to 0x1234; a_out=0x73; flag_out=0x20; done 4 cycles after start.
- RRD, A=0x84, mem=0x20, C=1, 3 wait cycles on each access → write 0x42; a_out=0x80; flag_out=0x81; latency 10.
- RLD, A=0x05, mem=0x00 → write 0x05; a_out=0x00; flag_out=0x44 (Z, P).
- ACK_TMO=4, no ack on read → rd_req high exactly 4 cycles; no wr_req; done with err=1; a_out=a_in.
- start pulsed during WR → ignored; one done only; busy low afterwards.
- reset asserted during RD with rd_req=1 → rd_req=0 same cycle; outputs zero; fresh start then completes normally.
